// File: rtl/pwl_activation_pipe.sv
// Multi-lane, two-stage piecewise-linear activation unit (hard sigmoid, hard tanh,
// relu, leaky relu) with valid/ready backpressure and a saturating clamp-event counter.
module pwl_activation_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_sat,
    input  logic                          sat_clr,
    output logic [CNT_WIDTH-1:0]          sat_count
);

    typedef enum logic [1:0] {
        MODE_HSIG  = 2'd0,
        MODE_HTANH = 2'd1,
        MODE_RELU  = 2'd2,
        MODE_LEAKY = 2'd3
    } mode_e;

    // One extra bit of headroom so x+TWO and the clamp compares cannot overflow.
    localparam int W = DATA_WIDTH + 1;
    localparam logic signed [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1} << FRACT_WIDTH;
    localparam logic signed [W-1:0] TWO_W = ONE_W <<< 1;

    logic                        en;
    logic                        s1_valid;
    mode_e                       s1_mode;
    logic [LANES*DATA_WIDTH-1:0] s1_data;
    logic [LANES*DATA_WIDTH-1:0] s2_data_next;
    logic [LANES-1:0]            s2_sat_next;
    logic [DATA_WIDTH:0]         lane_res;
    logic [CNT_WIDTH:0]          sat_pop;
    logic [CNT_WIDTH:0]          sat_sum;

    // The whole pipe advances unless the output holds a beat nobody takes.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; s1_valid alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            s1_mode <= mode_e'(in_mode);
            s1_data <= in_data;
        end
    end

    // Returns {sat, y} for one lane.
    function automatic logic [DATA_WIDTH:0] eval_lane(input logic [DATA_WIDTH-1:0] raw,
                                                      input mode_e mode);
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic                sat;
        x   = {raw[DATA_WIDTH-1], raw};
        y   = x;
        sat = 1'b0;
        case (mode)
            MODE_HSIG: begin
                if (x < -TWO_W) begin
                    y   = '0;
                    sat = 1'b1;
                end else if (x > TWO_W) begin
                    y   = ONE_W;
                    sat = 1'b1;
                end else begin
                    y = (x + TWO_W) >>> 2;
                end
            end
            MODE_HTANH: begin
                if (x < -ONE_W) begin
                    y   = -ONE_W;
                    sat = 1'b1;
                end else if (x > ONE_W) begin
                    y   = ONE_W;
                    sat = 1'b1;
                end
            end
            MODE_RELU: begin
                if (x[W-1]) begin
                    y = '0;
                end
            end
            MODE_LEAKY: begin
                if (x[W-1]) begin
                    y = x >>> 3;
                end
            end
            default: y = x;
        endcase
        return {sat, y[DATA_WIDTH-1:0]};
    endfunction

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        s2_data_next = '0;
        s2_sat_next  = '0;
        lane_res     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res = eval_lane(s1_data[i*DATA_WIDTH +: DATA_WIDTH], s1_mode);
            s2_data_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_res[DATA_WIDTH-1:0];
            s2_sat_next[i] = lane_res[DATA_WIDTH];
        end
    end

    // Results only load with a real beat, so out_data keeps its last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_data_next;
                out_sat  <= s2_sat_next;
            end
        end
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + {{CNT_WIDTH{1'b0}}, out_sat[i]};
        end
        sat_sum = {1'b0, sat_count} + sat_pop;
    end

    // Clear beats a coincident handshake; the carry bit pins the count at all-ones.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready) begin
            sat_count <= sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Self-checking bench for pwl_activation_pipe: directed vectors, per-beat modes, backpressure,
// counter clear/saturation, reset mid-stall and a randomized stream against an arithmetic model.
module tb_pwl_activation_pipe;

    localparam int DW  = 16;
    localparam int FW  = 8;
    localparam int LN  = 4;
    localparam int ONE = 1 << FW;
    localparam int TWO = 2 << FW;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [LN*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LN*DW-1:0] out_data;
    logic [LN-1:0]    out_sat;
    logic             sat_clr;
    logic [31:0]      sat_count;

    logic             in_valid4;
    logic             in_ready4;
    logic [1:0]       in_mode4;
    logic [LN*DW-1:0] in_data4;
    logic             out_valid4;
    logic             out_ready4;
    logic [LN*DW-1:0] out_data4;
    logic [LN-1:0]    out_sat4;
    logic             sat_clr4;
    logic [3:0]       sat_count4;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct { logic [1:0] mode; logic [LN*DW-1:0] data; } beat_t;
    typedef struct { logic [LN*DW-1:0] data; logic [LN-1:0] sat; } res_t;

    beat_t sent[$];
    res_t  got[$];

    pwl_activation_pipe #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW), .LANES(LN), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    pwl_activation_pipe #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW), .LANES(LN), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4),
        .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_sat(out_sat4), .sat_clr(sat_clr4), .sat_count(sat_count4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the activation rules written directly as integer arithmetic.
    function automatic int ref_lane(input int x, input int mode, output bit sat);
        sat = 1'b0;
        case (mode)
            0: begin
                if (x < -TWO) begin sat = 1'b1; return 0; end
                if (x > TWO)  begin sat = 1'b1; return ONE; end
                return (x + TWO) / 4;
            end
            1: begin
                if (x < -ONE) begin sat = 1'b1; return -ONE; end
                if (x > ONE)  begin sat = 1'b1; return ONE; end
                return x;
            end
            2: return (x < 0) ? 0 : x;
            default: return (x >= 0) ? x : -((-x + 7) / 8);
        endcase
    endfunction

    function automatic res_t ref_beat(input beat_t b);
        res_t r;
        int   x;
        int   y;
        bit   s;
        r.data = '0;
        r.sat  = '0;
        for (int i = 0; i < LN; i++) begin
            x = $signed(b.data[i*DW +: DW]);
            y = ref_lane(x, int'(b.mode), s);
            r.data[i*DW +: DW] = y[DW-1:0];
            r.sat[i] = s;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_sample();
        int v;
        case ($urandom_range(0, 2))
            0: v = int'($urandom_range(0, 65535)) - 32768;
            1: v = int'($urandom_range(0, 1400)) - 700;
            default: begin
                v = ($urandom_range(0, 1) != 0 ? TWO : ONE) + int'($urandom_range(0, 2)) - 1;
                if ($urandom_range(0, 1) != 0) v = -v;
            end
        endcase
        return v[DW-1:0];
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < LN; i++) b.data[i*DW +: DW] = rnd_sample();
        return b;
    endfunction

    // Advance one clock, logging accepted inputs and delivered outputs of the main DUT.
    task automatic tick();
        beat_t b;
        res_t  r;
        #1;
        if (!rst && in_valid && in_ready) begin
            b.mode = in_mode; b.data = in_data; sent.push_back(b);
        end
        if (!rst && out_valid && out_ready) begin
            r.data = out_data; r.sat = out_sat; got.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [1:0] mode, input logic [LN*DW-1:0] data,
                            output int lat, output res_t r);
        sent.delete(); got.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = mode; in_data = data;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin tick(); lat++; end
        r.data = out_data; r.sat = out_sat;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
        in_valid4 = 1'b0; in_mode4 = '0; in_data4 = '0; out_ready4 = 1'b1; sat_clr4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_sat !== '0) begin n_bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
        n_cmp++; if (sat_count4 !== 4'd0) begin n_bad++; $display("FAIL reset_sat_count4: got %0d want 0", sat_count4); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_hard_sigmoid();
        int   lat;
        res_t r;
        beat_t b;
        b.mode = 2'd0; b.data = {16'hFD00, 16'h0300, 16'h0100, 16'h0000};
        send_one(b.mode, b.data, lat, r);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hsig_latency: got %0d want 2", lat); end
        n_cmp++; if (r.data !== {16'h0000, 16'h0100, 16'h00C0, 16'h0080}) begin n_bad++; $display("FAIL hsig_data: got %h want 0000010000c00080", r.data); end
        n_cmp++; if (r.sat !== 4'b1100) begin n_bad++; $display("FAIL hsig_sat: got %b want 1100", r.sat); end
        n_cmp++; if (r.data !== ref_beat(b).data) begin n_bad++; $display("FAIL hsig_model: got %h want %h", r.data, ref_beat(b).data); end
        tick();
        exp_cnt += 2;
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL hsig_count: got %0d want %0d", sat_count, exp_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hsig_no_dup: got out_valid %0b want 0", out_valid); end

        send_one(2'd0, {16'h8000, 16'h7FFF, 16'hFE00, 16'h0200}, lat, r);
        n_cmp++; if (r.data !== {16'h0000, 16'h0100, 16'h0000, 16'h0100}) begin n_bad++; $display("FAIL hsig_endpoints_data: got %h want 0000010000000100", r.data); end
        n_cmp++; if (r.sat !== 4'b1100) begin n_bad++; $display("FAIL hsig_endpoints_sat: got %b want 1100", r.sat); end
        tick();
        exp_cnt += 2;
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL hsig_endpoints_count: got %0d want %0d", sat_count, exp_cnt); end
    endtask

    task automatic test_mode_per_beat();
        beat_t src[3];
        res_t  e;
        src[0].mode = 2'd1; src[0].data = {16'h0200, 16'h0000, 16'h0080, 16'hFE00};
        src[1].mode = 2'd3; src[1].data = {16'h7FFF, 16'h8000, 16'h0040, 16'hFF00};
        src[2].mode = 2'd2; src[2].data = {16'h0100, 16'h8000, 16'h0040, 16'hFF00};
        sent.delete(); got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = src[i].mode; in_data = src[i].data;
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && got.size() < 3; c++) tick();
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL modes_count: got %0d beats want 3", got.size()); end
        if (got.size() == 3) begin
            n_cmp++; if (got[0].data[31:0] !== {16'h0080, 16'hFF00}) begin n_bad++; $display("FAIL modes_tanh: got %h want 0080ff00", got[0].data[31:0]); end
            n_cmp++; if (got[1].data[31:0] !== {16'h0040, 16'hFFE0}) begin n_bad++; $display("FAIL modes_leaky: got %h want 0040ffe0", got[1].data[31:0]); end
            n_cmp++; if (got[2].data[15:0] !== 16'h0000) begin n_bad++; $display("FAIL modes_relu: got %h want 0000", got[2].data[15:0]); end
            for (int i = 0; i < 3; i++) begin
                e = ref_beat(src[i]);
                exp_cnt += $countones(e.sat);
                n_cmp++; if (got[i].data !== e.data || got[i].sat !== e.sat) begin
                    n_bad++; $display("FAIL modes_model[%0d]: got %h/%b want %h/%b", i, got[i].data, got[i].sat, e.data, e.sat);
                end
            end
        end
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL modes_sat_count: got %0d want %0d", sat_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        beat_t            src[6];
        res_t             e;
        logic [LN*DW-1:0] held;
        bit               first_seen = 1'b0;
        int               stall = 0;
        for (int i = 0; i < 6; i++) src[i] = rnd_beat();
        sent.delete(); got.delete();
        out_ready = 1'b1;
        held = '0;
        for (int c = 0; c < 100 && got.size() < 6; c++) begin
            in_valid = (sent.size() < 6);
            if (sent.size() < 6) begin in_mode = src[sent.size()].mode; in_data = src[sent.size()].data; end
            if (!first_seen && out_valid) begin first_seen = 1'b1; stall = 3; held = out_data; end
            out_ready = (stall == 0);
            if (stall > 0) begin
                #1;
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
                n_cmp++; if (out_data !== held) begin n_bad++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
                stall--;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (sent.size() != 6) begin n_bad++; $display("FAIL bp_accepted: got %0d want 6", sent.size()); end
        n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL bp_delivered: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            e = ref_beat(src[i]);
            exp_cnt += $countones(e.sat);
            n_cmp++; if (got[i].data !== e.data || got[i].sat !== e.sat) begin
                n_bad++; $display("FAIL bp_order[%0d]: got %h/%b want %h/%b", i, got[i].data, got[i].sat, e.data, e.sat);
            end
        end
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL bp_sat_count: got %0d want %0d", sat_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        beat_t            src[N];
        res_t             e;
        logic [LN*DW-1:0] held;
        bit               was_stall;
        for (int i = 0; i < N; i++) src[i] = rnd_beat();
        sent.delete(); got.delete();
        held = '0;
        for (int c = 0; c < 2000 && got.size() < N; c++) begin
            in_valid = (sent.size() < N) && ($urandom_range(0, 3) != 0);
            if (sent.size() < N) begin in_mode = src[sent.size()].mode; in_data = src[sent.size()].data; end
            out_ready = ($urandom_range(0, 3) != 0);
            was_stall = out_valid && !out_ready;
            held = out_data;
            tick();
            if (was_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
                    n_bad++; $display("FAIL rand_hold: got %0b/%h want 1/%h", out_valid, out_data, held);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got.size() != N) begin n_bad++; $display("FAIL rand_delivered: got %0d want %0d", got.size(), N); end
        for (int i = 0; i < N && i < got.size(); i++) begin
            e = ref_beat(src[i]);
            exp_cnt += $countones(e.sat);
            n_cmp++; if (got[i].data !== e.data || got[i].sat !== e.sat) begin
                n_bad++; $display("FAIL rand_beat[%0d] mode %0d in %h: got %h/%b want %h/%b", i, src[i].mode, src[i].data, got[i].data, got[i].sat, e.data, e.sat);
            end
        end
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL rand_sat_count: got %0d want %0d", sat_count, exp_cnt); end
    endtask

    task automatic test_sat_clear();
        int   lat;
        res_t r;
        n_cmp++; if (sat_count !== 32'(exp_cnt)) begin n_bad++; $display("FAIL clr_before: got %0d want %0d", sat_count, exp_cnt); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 2'd1; in_data = {16'h0000, 16'h0000, 16'h9000, 16'h7000};
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_sat !== 4'b0011) begin n_bad++; $display("FAIL clr_beat: got %0b/%b want 1/0011", out_valid, out_sat); end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        exp_cnt = 0;
        n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("FAIL clr_wins: got %0d want 0", sat_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_consumed: got %0b want 0", out_valid); end
        send_one(2'd0, {16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, lat, r);
        tick();
        exp_cnt = 1;
        n_cmp++; if (sat_count !== 32'd1) begin n_bad++; $display("FAIL clr_recount: got %0d want 1", sat_count); end
    endtask

    task automatic send4(input logic [1:0] mode, input logic [LN*DW-1:0] data, input int n);
        in_valid4 = 1'b1; in_mode4 = mode; in_data4 = data;
        repeat (n) tick();
        in_valid4 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_count_saturate();
        send4(2'd0, {4{16'h7FFF}}, 3);
        n_cmp++; if (sat_count4 !== 4'd12) begin n_bad++; $display("FAIL cnt4_twelve: got %0d want 12", sat_count4); end
        send4(2'd0, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000}, 1);
        n_cmp++; if (sat_count4 !== 4'd15) begin n_bad++; $display("FAIL cnt4_exact_full: got %0d want 15", sat_count4); end
        send4(2'd0, {4{16'h8000}}, 2);
        n_cmp++; if (sat_count4 !== 4'd15) begin n_bad++; $display("FAIL cnt4_sticks: got %0d want 15", sat_count4); end
    endtask

    task automatic test_reset_mid_stall();
        int seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd0; in_data = {4{16'h7FFF}};
        tick();
        in_data = {4{16'h0100}};
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_stall_setup: got %0b/%0b want 1/0", out_valid, in_ready); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_stall_data: got %h want 0", out_data); end
        n_cmp++; if (out_sat !== '0) begin n_bad++; $display("FAIL rst_stall_sat: got %b want 0", out_sat); end
        n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("FAIL rst_stall_count: got %0d want 0", sat_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_in_ready: got %0b want 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_stale_beat: got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_hard_sigmoid();
        test_mode_per_beat();
        test_backpressure();
        test_back_to_back();
        test_sat_clear();
        test_count_saturate();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
